// File: rtl/graph_sequencer_if.sv
// Purpose: bundles the update stream, adjacency write port, engine handshakes
//          and pass status of graph_sequencer into one interface.
// Signals:
//   upd_valid/upd_ready/upd_src/upd_dst/upd_e  edge update stream (valid/ready)
//   run_req                                    request a detection pass (pulse)
//   adj_we/adj_row/adj_col/adj_data            adjacency matrix write port
//   stage_reset/stage_done                     one-hot engine start / engine done level
//   active_stage                               engine owning the matrix read ports, 7 = none
//   busy/pass_done/timeout/pass_count          pass status
// Modports: slave = the sequencer, master = the surrounding environment.
interface graph_sequencer_if #(
  parameter int unsigned PRED_W     = 8,
  parameter int unsigned WEIGHT_W   = 32,
  parameter int unsigned NUM_STAGES = 3
);
  logic                  upd_valid;
  logic                  upd_ready;
  logic [PRED_W-1:0]     upd_src;
  logic [PRED_W-1:0]     upd_dst;
  logic [WEIGHT_W-1:0]   upd_e;
  logic                  run_req;
  logic                  adj_we;
  logic [PRED_W-1:0]     adj_row;
  logic [PRED_W-1:0]     adj_col;
  logic [WEIGHT_W-1:0]   adj_data;
  logic [NUM_STAGES-1:0] stage_reset;
  logic [NUM_STAGES-1:0] stage_done;
  logic [2:0]            active_stage;
  logic                  busy;
  logic                  pass_done;
  logic                  timeout;
  logic [15:0]           pass_count;

  modport slave (
    input  upd_valid, upd_src, upd_dst, upd_e, run_req, stage_done,
    output upd_ready, adj_we, adj_row, adj_col, adj_data, stage_reset,
           active_stage, busy, pass_done, timeout, pass_count
  );

  modport master (
    output upd_valid, upd_src, upd_dst, upd_e, run_req, stage_done,
    input  upd_ready, adj_we, adj_row, adj_col, adj_data, stage_reset,
           active_stage, busy, pass_done, timeout, pass_count
  );
endinterface

// File: rtl/graph_sequencer.sv
// Purpose: pass sequencer for the arbitrage graph engine. Buffers edge updates
//          in a FIFO and writes each into the adjacency matrix (forward edge plus
//          optional reverse edge), then on request runs NUM_STAGES detection
//          engines in turn with a per-stage watchdog.
// Ports:
//   clk        system clock
//   seq_reset  synchronous active-high reset
//   bus        graph_sequencer_if.slave (update stream, adjacency write port,
//              engine start/done handshakes, pass status)
module graph_sequencer #(
  parameter int unsigned PRED_W      = 8,
  parameter int unsigned WEIGHT_W    = 32,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned NUM_STAGES  = 3,
  parameter int unsigned REV_MODE    = 1,
  parameter int unsigned TIMEOUT_CYC = 65535
) (
  input logic clk,
  input logic seq_reset,
  graph_sequencer_if.slave bus
);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned ENT_W = 2 * PRED_W + WEIGHT_W;
  localparam int unsigned WD_W  = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_FOR, S_WR_REV, S_LAUNCH, S_GAP, S_WAIT, S_DONE
  } state_t;

  // ---------------- update FIFO ----------------
  logic [ENT_W-1:0]    mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]      count_q;
  logic                push, pop, full, empty;
  logic [PRED_W-1:0]   head_src, head_dst;
  logic [WEIGHT_W-1:0] head_e;

  assign full          = (count_q == (PTR_W+1)'(FIFO_DEPTH));
  assign empty         = (count_q == '0);
  assign bus.upd_ready = !full && !seq_reset;
  assign push          = bus.upd_valid && bus.upd_ready;
  assign {head_src, head_dst, head_e} = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {bus.upd_src, bus.upd_dst, bus.upd_e};
  end

  always_ff @(posedge clk) begin
    if (seq_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // ---------------- pass sequencer ----------------
  state_t            state_q, state_d;
  logic [1:0]        k_q, k_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              run_pending_q, clr_pending, timeout_set;
  logic              timeout_q;
  logic [15:0]       pass_count_q;

  logic                  adj_we;
  logic [PRED_W-1:0]     adj_row, adj_col;
  logic [WEIGHT_W-1:0]   adj_data;
  logic [NUM_STAGES-1:0] stage_reset;
  logic                  pass_done;

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    wd_d        = wd_q;
    pop         = 1'b0;
    clr_pending = 1'b0;
    timeout_set = 1'b0;
    adj_we      = 1'b0;
    adj_row     = '0;
    adj_col     = '0;
    adj_data    = '0;
    stage_reset = '0;
    pass_done   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          state_d = S_WR_FOR;
        end else if (run_pending_q) begin
          k_d         = '0;
          clr_pending = 1'b1;
          state_d     = S_LAUNCH;
        end
      end
      S_WR_FOR: begin
        adj_we   = 1'b1;
        adj_row  = head_src;
        adj_col  = head_dst;
        adj_data = head_e;
        if (REV_MODE == 0) begin
          pop     = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_WR_REV;
        end
      end
      S_WR_REV: begin
        adj_we   = 1'b1;
        adj_row  = head_dst;
        adj_col  = head_src;
        adj_data = (REV_MODE == 2) ? ('0 - head_e) : '0;
        pop      = 1'b1;
        state_d  = S_IDLE;
      end
      S_LAUNCH: begin
        stage_reset = NUM_STAGES'(1) << k_q;
        wd_d        = '0;
        state_d     = S_GAP;
      end
      S_GAP: state_d = S_WAIT;
      S_WAIT: begin
        // wd_d counts this WAIT cycle, so the abort lands on WAIT cycle TIMEOUT_CYC
        wd_d = wd_q + WD_W'(1);
        if (bus.stage_done[k_q]) begin
          if (k_q == 2'(NUM_STAGES - 1)) begin
            state_d = S_DONE;
          end else begin
            k_d     = k_q + 2'd1;
            state_d = S_LAUNCH;
          end
        end else if (wd_d == WD_W'(TIMEOUT_CYC)) begin
          timeout_set = 1'b1;
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        pass_done = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (seq_reset) begin
      state_q       <= S_IDLE;
      k_q           <= '0;
      wd_q          <= '0;
      run_pending_q <= 1'b0;
      timeout_q     <= 1'b0;
      pass_count_q  <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      wd_q    <= wd_d;
      // a request arriving on the consume cycle still queues a further pass
      if (bus.run_req)      run_pending_q <= 1'b1;
      else if (clr_pending) run_pending_q <= 1'b0;
      if (timeout_set) timeout_q <= 1'b1;
      if (pass_done)   pass_count_q <= pass_count_q + 16'd1;
    end
  end

  assign bus.adj_we       = adj_we;
  assign bus.adj_row      = adj_row;
  assign bus.adj_col      = adj_col;
  assign bus.adj_data     = adj_data;
  assign bus.stage_reset  = stage_reset;
  assign bus.pass_done    = pass_done;
  assign bus.busy         = (state_q != S_IDLE);
  assign bus.active_stage = (state_q == S_LAUNCH || state_q == S_GAP || state_q == S_WAIT)
                            ? {1'b0, k_q} : 3'd7;
  assign bus.timeout      = timeout_q;
  assign bus.pass_count   = pass_count_q;
endmodule

// File: tb/tb_graph_sequencer.sv
module tb_graph_sequencer;
  localparam int NS = 3;

  logic clk = 1'b0;
  logic seq_reset;
  always #5 clk = ~clk;

  graph_sequencer_if #(.PRED_W(8), .WEIGHT_W(32), .NUM_STAGES(NS)) bus ();

  graph_sequencer #(
    .PRED_W(8), .WEIGHT_W(32), .FIFO_DEPTH(8), .NUM_STAGES(NS),
    .REV_MODE(2), .TIMEOUT_CYC(20)
  ) dut (
    .clk(clk), .seq_reset(seq_reset), .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Engine models: after a start pulse, raise done lat[k] cycles later (0 = never).
  int lat [NS];
  int ecnt [NS];
  initial begin
    bus.stage_done = '0;
    for (int k = 0; k < NS; k++) begin lat[k] = 5; ecnt[k] = 0; end
  end
  always @(posedge clk) begin
    for (int k = 0; k < NS; k++) begin
      if (bus.stage_reset[k]) begin
        bus.stage_done[k] <= 1'b0;
        ecnt[k] <= lat[k];
      end else if (ecnt[k] != 0) begin
        ecnt[k] <= ecnt[k] - 1;
        if (ecnt[k] == 1) bus.stage_done[k] <= 1'b1;
      end
    end
  end

  // Reference: every accepted update yields forward and negated reverse writes, in order.
  logic [47:0] wq [$];
  int sr_log [$];
  int pd_cnt = 0, a1_cnt = 0, cyc = 0, launch0_cyc = 0, done_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!seq_reset) begin
      if (bus.adj_we) begin
        chk("wr_outside_pass", {61'd0, bus.active_stage}, 64'd7);
        if (wq.size() == 0) chk("unexpected_write", 64'd1, 64'd0);
        else chk("adj_write", {16'd0, bus.adj_row, bus.adj_col, bus.adj_data}, {16'd0, wq.pop_front()});
      end
      if (bus.stage_reset != '0) begin
        chk("sr_onehot", 64'($countones(bus.stage_reset)), 64'd1);
        for (int k = 0; k < NS; k++) if (bus.stage_reset[k]) sr_log.push_back(k);
        if (bus.stage_reset[0]) launch0_cyc = cyc;
      end
      if (bus.pass_done) begin pd_cnt++; done_cyc = cyc; end
      if (bus.active_stage == 3'd1) a1_cnt++;
    end
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
  endtask

  task automatic push(input logic [7:0] s, input logic [7:0] d, input logic [31:0] e);
    bit acc = 0;
    bus.upd_valid = 1'b1; bus.upd_src = s; bus.upd_dst = d; bus.upd_e = e;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (bus.upd_ready) begin
        acc = 1;
        wq.push_back({s, d, e});
        wq.push_back({d, s, 32'd0 - e});
        tick();
        break;
      end
      tick();
    end
    bus.upd_valid = 1'b0;
    chk("push_accepted", 64'(acc), 64'd1);
  endtask

  task automatic pulse_run();
    bus.run_req = 1'b1; tick(); bus.run_req = 1'b0;
  endtask

  task automatic wait_stage(input int k, input string tag);
    bit ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.active_stage == 3'(k)) begin ok = 1; break; end
    end
    chk(tag, 64'(ok), 64'd1);
  endtask

  task automatic wait_pd(input int target, input string tag);
    bit ok = 0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (pd_cnt >= target) begin ok = 1; break; end
    end
    chk(tag, 64'(ok), 64'd1);
  endtask

  task automatic wait_drain(input string tag);
    bit ok = 0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (wq.size() == 0 && !bus.busy) begin ok = 1; break; end
    end
    chk(tag, 64'(ok), 64'd1);
  endtask

  int pd0;

  initial begin
    seq_reset = 1'b1;
    bus.upd_valid = 1'b0; bus.upd_src = '0; bus.upd_dst = '0; bus.upd_e = '0;
    bus.run_req = 1'b0;
    tick(2);
    chk("ready_in_reset", 64'(bus.upd_ready), 64'd0);
    seq_reset = 1'b0;
    tick(10);
    chk("rst_ready", 64'(bus.upd_ready), 64'd1);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_stage_reset", 64'(bus.stage_reset), 64'd0);
    chk("rst_active", 64'(bus.active_stage), 64'd7);
    chk("rst_pass_count", 64'(bus.pass_count), 64'd0);
    chk("rst_timeout", 64'(bus.timeout), 64'd0);

    // Reset while waiting on stage 1 aborts the pass silently.
    lat[0] = 5; lat[1] = 0; lat[2] = 5;
    pulse_run();
    wait_stage(1, "mid_reach_s1");
    tick(3);
    pd0 = pd_cnt;
    seq_reset = 1'b1;
    #1 chk("mid_ready_in_reset", 64'(bus.upd_ready), 64'd0);
    tick();
    seq_reset = 1'b0;
    chk("mid_busy", 64'(bus.busy), 64'd0);
    chk("mid_active", 64'(bus.active_stage), 64'd7);
    chk("mid_stage_reset", 64'(bus.stage_reset), 64'd0);
    chk("mid_pass_count", 64'(bus.pass_count), 64'd0);
    tick(30);
    chk("mid_no_pass_done", 64'(pd_cnt), 64'(pd0));
    chk("mid_stays_idle", 64'(bus.busy), 64'd0);
    chk("mid_no_timeout", 64'(bus.timeout), 64'd0);

    // Directed reverse-negate update, then random ones including the minimum weight.
    push(8'd3, 8'd5, 32'd100);
    wait_drain("rev_drain");
    push(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 32'h8000_0000);
    for (int i = 0; i < 4; i++) push(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), $urandom);
    wait_drain("rand_drain");

    // Queued updates drain before stage 0 starts; three stages in order.
    lat[0] = 5; lat[1] = 5; lat[2] = 5;
    sr_log.delete();
    pd0 = pd_cnt;
    push(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), $urandom);
    push(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), $urandom);
    pulse_run();
    wait_stage(0, "p1_reach_s0");
    chk("p1_writes_before_run", 64'(wq.size()), 64'd0);
    wait_pd(pd0 + 1, "p1_pass_done");
    tick(5);
    chk("p1_sr_count", 64'(sr_log.size()), 64'd3);
    for (int i = 0; i < 3; i++) chk("p1_sr_order", 64'(sr_log[i]), 64'(i));
    chk("p1_pd_once", 64'(pd_cnt), 64'(pd0 + 1));
    chk("p1_pass_count", 64'(bus.pass_count), 64'd1);

    // Minimum latency: launch of stage 0 to pass_done spans 3*NS+1 cycles.
    lat[0] = 1; lat[1] = 1; lat[2] = 1;
    pd0 = pd_cnt;
    pulse_run();
    wait_pd(pd0 + 1, "lat_pass_done");
    chk("lat_cycles", 64'(done_cyc - launch0_cyc + 1), 64'(3 * NS + 1));
    chk("lat_pass_count", 64'(bus.pass_count), 64'd2);

    // Two requests during a pass queue exactly one further pass.
    lat[0] = 5; lat[1] = 5; lat[2] = 5;
    pd0 = pd_cnt;
    pulse_run();
    tick(4);
    pulse_run();
    tick(3);
    pulse_run();
    wait_pd(pd0 + 2, "q_two_passes");
    tick(60);
    chk("q_pd_count", 64'(pd_cnt), 64'(pd0 + 2));
    chk("q_idle", 64'(bus.busy), 64'd0);
    chk("q_pass_count", 64'(bus.pass_count), 64'd4);

    // Fill the FIFO during a pass: ready drops at 8 entries, 9th waits, all written in order.
    lat[0] = 15; lat[1] = 15; lat[2] = 15;
    pd0 = pd_cnt;
    pulse_run();
    wait_stage(0, "full_reach_s0");
    tick();
    for (int i = 0; i < 8; i++) push(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), $urandom);
    @(negedge clk);
    chk("full_ready_low", 64'(bus.upd_ready), 64'd0);
    chk("full_in_pass", 64'(bus.active_stage != 3'd7), 64'd1);
    tick();
    push(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), $urandom);
    wait_drain("full_drain");
    chk("full_pass_count", 64'(bus.pass_count), 64'd5);
    chk("full_ready_back", 64'(bus.upd_ready), 64'd1);

    // Stage 1 never finishes: abort after 20 WAIT cycles, stage 2 skipped.
    lat[0] = 3; lat[1] = 0; lat[2] = 3;
    sr_log.delete();
    a1_cnt = 0;
    pd0 = pd_cnt;
    pulse_run();
    wait_pd(pd0 + 1, "to_pass_done");
    tick(5);
    chk("to_timeout", 64'(bus.timeout), 64'd1);
    chk("to_sr_count", 64'(sr_log.size()), 64'd2);
    for (int i = 0; i < sr_log.size(); i++) chk("to_sr_order", 64'(sr_log[i]), 64'(i));
    chk("to_stage1_cycles", 64'(a1_cnt), 64'd22);
    chk("to_pd_once", 64'(pd_cnt), 64'(pd0 + 1));
    chk("to_pass_count", 64'(bus.pass_count), 64'd6);

    // Reset clears the sticky timeout and the pass counter.
    seq_reset = 1'b1;
    tick();
    seq_reset = 1'b0;
    tick();
    chk("end_timeout_clr", 64'(bus.timeout), 64'd0);
    chk("end_pass_count_clr", 64'(bus.pass_count), 64'd0);
    chk("end_ready", 64'(bus.upd_ready), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
